// File: rtl/stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// stopwatch_ctrl: sequences the MM:SS stopwatch from the divider's level clocks.
//   Edge-detects one_hz/two_hz/seg_clk/pause_btn in the clk domain and runs a
//   RUN/PAUSED/ADJUST FSM. It also scans a 4-digit active-low 7-segment
//   display and blinks the field being adjusted.
// Ports:
//   i_clk, i_reset          : 100 MHz clock, asynchronous active-high reset
//   i_one_hz, i_two_hz      : count / adjust-step square waves
//   i_seg_clk, i_blink_clk  : display scan and blink square waves
//   i_pause_btn, i_adj, i_sel : debounced controls (toggle pause, adjust, field)
//   i_lap                   : lap snapshot toggle (STOPWATCH_LAP_EN only)
//   o_minutes, o_seconds    : live count
//   o_an, o_seg             : digit enables (one-hot) and segments {g..a}, active-low
// Optional feature macro: STOPWATCH_LAP_EN (adds i_lap and the display snapshot).
//------------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int MAX_MIN          = 99,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_one_hz,
  input  logic       i_two_hz,
  input  logic       i_seg_clk,
  input  logic       i_blink_clk,
  input  logic       i_pause_btn,
  input  logic       i_adj,
  input  logic       i_sel,
`ifdef STOPWATCH_LAP_EN
  input  logic       i_lap,
`endif
  output logic [6:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic [3:0] o_an,
  output logic [6:0] o_seg
);

  localparam logic [6:0] MAXM   = 7'(MAX_MIN);
  localparam logic [3:0] AN_OFF = (ANODE_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  localparam int E_ONE   = 0;
  localparam int E_TWO   = 1;
  localparam int E_SEG   = 2;
  localparam int E_PAUSE = 3;

`ifdef STOPWATCH_LAP_EN
  localparam int E_LAP = 4;
  localparam int NEV   = 5;
  logic [NEV-1:0] w_ev_in;
  assign w_ev_in = {i_lap, i_pause_btn, i_seg_clk, i_two_hz, i_one_hz};
`else
  localparam int NEV = 4;
  logic [NEV-1:0] w_ev_in;
  assign w_ev_in = {i_pause_btn, i_seg_clk, i_two_hz, i_one_hz};
`endif

  typedef enum logic [1:0] {S_RUN, S_PAUSED, S_ADJUST} state_t;

  // Edge-detected inputs: registered value and its history. Both reset high so
  // a level already high at reset release does not produce an event.
  logic [NEV-1:0] r_ev_q, r_ev_p, w_ev;
  // adj and blink are consumed as levels, so only the registering flop is
  // kept. adj resets low so the FSM sees no phantom adjust request right
  // after reset. blink resets high so nothing is blanked.
  logic           r_adj_q, r_blink_q;
  state_t         r_state, r_resume;
  logic [6:0]     r_min;
  logic [5:0]     r_sec;
  logic [1:0]     r_idx;
  logic [3:0]     r_an;
  logic [6:0]     r_seg;

  assign w_ev = r_ev_q & ~r_ev_p;

`ifdef STOPWATCH_LAP_EN
  logic       r_frozen;
  logic [6:0] r_snap_min;
  logic [5:0] r_snap_sec;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ev_q     <= '1;
      r_ev_p     <= '1;
      r_adj_q    <= 1'b0;
      r_blink_q  <= 1'b1;
      r_state    <= S_RUN;
      r_resume   <= S_RUN;
      r_min      <= 7'd0;
      r_sec      <= 6'd0;
      r_idx      <= 2'd0;
`ifdef STOPWATCH_LAP_EN
      r_frozen   <= 1'b0;
      r_snap_min <= 7'd0;
      r_snap_sec <= 6'd0;
`endif
    end else begin
      r_ev_q    <= w_ev_in;
      r_ev_p    <= r_ev_q;
      r_adj_q   <= i_adj;
      r_blink_q <= i_blink_clk;
      if (w_ev[E_SEG]) r_idx <= r_idx + 2'd1;
      case (r_state)
        S_RUN: begin
          if (r_adj_q) begin
            // Adjust request wins over a same-cycle one_hz event.
            r_state  <= S_ADJUST;
            r_resume <= S_RUN;
`ifdef STOPWATCH_LAP_EN
            r_frozen <= 1'b0;
`endif
          end else begin
            if (w_ev[E_ONE]) begin
              if (r_sec == 6'd59) begin
                r_sec <= 6'd0;
                r_min <= (r_min == MAXM) ? 7'd0 : r_min + 7'd1;
              end else begin
                r_sec <= r_sec + 6'd1;
              end
            end
            if (w_ev[E_PAUSE]) r_state <= S_PAUSED;
`ifdef STOPWATCH_LAP_EN
            if (w_ev[E_LAP]) begin
              r_frozen   <= ~r_frozen;
              r_snap_min <= r_min;
              r_snap_sec <= r_sec;
            end
`endif
          end
        end
        S_PAUSED: begin
          if (r_adj_q) begin
            r_state  <= S_ADJUST;
            r_resume <= S_PAUSED;
`ifdef STOPWATCH_LAP_EN
            r_frozen <= 1'b0;
`endif
          end else if (w_ev[E_PAUSE]) begin
            r_state <= S_RUN;
          end
        end
        S_ADJUST: begin
          // Pause events are deliberately dropped here.
          if (!r_adj_q) begin
            r_state <= r_resume;
          end else if (w_ev[E_TWO]) begin
            if (i_sel) r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
            else       r_min <= (r_min == MAXM)  ? 7'd0 : r_min + 7'd1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Tens digit by constant compares (value never exceeds 99).
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    logic [3:0] t;
    t = 4'd0;
    for (int k = 1; k <= 9; k++)
      if (v >= 7'(10 * k)) t = 4'(k);
    return t;
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    logic [6:0] t;
    t = {3'd0, tens_of(v)};
    return 4'(v - ((t << 3) + (t << 1)));
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  logic [6:0] w_disp_min;
  logic [5:0] w_disp_sec;
`ifdef STOPWATCH_LAP_EN
  assign w_disp_min = r_frozen ? r_snap_min : r_min;
  assign w_disp_sec = r_frozen ? r_snap_sec : r_sec;
`else
  assign w_disp_min = r_min;
  assign w_disp_sec = r_sec;
`endif

  logic [3:0] w_digit;
  logic [3:0] w_hot;
  logic       w_blank;

  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      2'd0: w_digit = ones_of({1'b0, w_disp_sec});
      2'd1: w_digit = tens_of({1'b0, w_disp_sec});
      2'd2: w_digit = ones_of(w_disp_min);
      2'd3: w_digit = tens_of(w_disp_min);
      default: w_digit = 4'd0;
    endcase
  end

  assign w_hot   = 4'b0001 << r_idx;
  // Digits 0/1 belong to seconds, 2/3 to minutes.
  assign w_blank = (r_state == S_ADJUST) && !r_blink_q &&
                   (i_sel ? (r_idx < 2'd2) : (r_idx >= 2'd2));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_an  <= AN_OFF;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= (ANODE_ACTIVE_LOW != 0) ? ~w_hot : w_hot;
      r_seg <= w_blank ? 7'h7F : seg_of(w_digit);
    end
  end

  assign o_minutes = r_min;
  assign o_seconds = r_sec;
  assign o_an      = r_an;
  assign o_seg     = r_seg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  localparam int MAXM = 99;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic one_hz = 1'b0, two_hz = 1'b0, seg_clk = 1'b0, blink_clk = 1'b1;
  logic pause_btn = 1'b0, adj = 1'b0, sel = 1'b0;
`ifdef STOPWATCH_LAP_EN
  logic lap = 1'b0;
`endif
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic [3:0] an;
  logic [6:0] seg;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: count kept as plain integers, state as simple flags.
  int m_min, m_sec, m_idx, m_snap_min, m_snap_sec;
  bit m_paused, m_adj, m_frozen;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  stopwatch_ctrl #(.MAX_MIN(MAXM), .ANODE_ACTIVE_LOW(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_one_hz(one_hz), .i_two_hz(two_hz),
    .i_seg_clk(seg_clk), .i_blink_clk(blink_clk), .i_pause_btn(pause_btn),
    .i_adj(adj), .i_sel(sel),
`ifdef STOPWATCH_LAP_EN
    .i_lap(lap),
`endif
    .o_minutes(minutes), .o_seconds(seconds), .o_an(an), .o_seg(seg)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic void m_reset();
    m_min = 0; m_sec = 0; m_idx = 0; m_paused = 0; m_adj = 0; m_frozen = 0;
    m_snap_min = 0; m_snap_sec = 0;
  endfunction

  function automatic void m_tick();
    int total;
    if (m_adj || m_paused) return;
    total = (m_min * 60 + m_sec + 1) % ((MAXM + 1) * 60);
    m_min = total / 60;
    m_sec = total % 60;
  endfunction

  function automatic logic [6:0] exp_seg(input int idx);
    int mm, ss, d;
    mm = m_frozen ? m_snap_min : m_min;
    ss = m_frozen ? m_snap_sec : m_sec;
    if (m_adj && !blink_clk && (sel ? (idx < 2) : (idx >= 2))) return 7'h7F;
    case (idx)
      0: d = ss % 10;
      1: d = ss / 10;
      2: d = mm % 10;
      default: d = mm / 10;
    endcase
    return seg_tab[d];
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    logic [3:0] hot;
    hot = 4'b0001 << idx;
    return ~hot;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_one();
    one_hz = 1; clks(3); one_hz = 0; clks(3);
    m_tick();
  endtask

  task automatic pulse_two();
    two_hz = 1; clks(3); two_hz = 0; clks(3);
    if (m_adj) begin
      if (sel) m_sec = (m_sec + 1) % 60;
      else     m_min = (m_min + 1) % (MAXM + 1);
    end
  endtask

  task automatic pulse_seg();
    seg_clk = 1; clks(3); seg_clk = 0; clks(3);
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic pulse_pause();
    pause_btn = 1; clks(3); pause_btn = 0; clks(3);
    if (!m_adj) m_paused = !m_paused;
  endtask

  task automatic pulse_both();
    one_hz = 1; pause_btn = 1; clks(3); one_hz = 0; pause_btn = 0; clks(3);
    m_tick();
    if (!m_adj) m_paused = !m_paused;
  endtask

  task automatic enter_adj(input logic s);
    sel = s; adj = 1; clks(3);
    m_adj = 1; m_frozen = 0;
  endtask

  task automatic exit_adj();
    adj = 0; clks(3);
    m_adj = 0;
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic pulse_lap();
    lap = 1; clks(3); lap = 0; clks(3);
    if (!m_adj && !m_paused) begin
      m_frozen = !m_frozen;
      m_snap_min = m_min; m_snap_sec = m_sec;
    end
  endtask
`endif

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; clks(2);
    n_chk++;
    if ({minutes, seconds, an, seg} !== {7'd0, 6'd0, 4'hF, 7'h7F})
      $display("FAIL reset_vals: got %0d:%0d an=%b seg=%b expected 0:0 an=1111 seg=1111111",
               minutes, seconds, an, seg);
    else n_pass++;
    reset = 0; m_reset(); clks(1);
    n_chk++;
    if ({an, seg} !== {4'b1110, 7'b1000000})
      $display("FAIL reset_first_scan: got an=%b seg=%b expected an=1110 seg=1000000", an, seg);
    else n_pass++;
  endtask

  task automatic test_count_scan();
    one_hz = 1;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (seconds !== 6'd0) $display("FAIL latency_early: got %0d expected 0", seconds);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (seconds !== 6'd1) $display("FAIL latency_apply: got %0d expected 1", seconds);
    else n_pass++;
    clks(1); one_hz = 0; clks(3); m_tick();
    pulse_one(); pulse_one();
    clks(1);
    n_chk++;
    if ({minutes, seconds, an, seg} !== {7'd0, 6'd3, 4'b1110, 7'b0110000})
      $display("FAIL count3: got %0d:%0d an=%b seg=%b expected 0:3 an=1110 seg=0110000",
               minutes, seconds, an, seg);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pulse_seg();
      n_chk++;
      if ({an, seg} !== {exp_an(m_idx), exp_seg(m_idx)})
        $display("FAIL scan_%0d: got an=%b seg=%b expected an=%b seg=%b",
                 i, an, seg, exp_an(m_idx), exp_seg(m_idx));
      else n_pass++;
    end
  endtask

  task automatic test_carry();
    enter_adj(0); pulse_two();
    sel = 1; repeat (56) pulse_two();
    exit_adj();
    n_chk++;
    if ({minutes, seconds} !== {7'd1, 6'd59})
      $display("FAIL preload_0159: got %0d:%0d expected 1:59", minutes, seconds);
    else n_pass++;
    pulse_one();
    n_chk++;
    if ({minutes, seconds} !== {7'd2, 6'd0})
      $display("FAIL carry_0200: got %0d:%0d expected 2:0", minutes, seconds);
    else n_pass++;
    enter_adj(0); repeat (97) pulse_two();
    sel = 1; repeat (59) pulse_two();
    exit_adj();
    n_chk++;
    if ({minutes, seconds} !== {7'd99, 6'd59})
      $display("FAIL preload_9959: got %0d:%0d expected 99:59", minutes, seconds);
    else n_pass++;
    pulse_one();
    n_chk++;
    if ({minutes, seconds} !== {7'd0, 6'd0})
      $display("FAIL wrap_0000: got %0d:%0d expected 0:0", minutes, seconds);
    else n_pass++;
  endtask

  task automatic test_simul();
    enter_adj(1); repeat (10) pulse_two(); exit_adj();
    pulse_both();
    n_chk++;
    if ({minutes, seconds} !== {7'd0, 6'd11})
      $display("FAIL simul_inc: got %0d:%0d expected 0:11", minutes, seconds);
    else n_pass++;
    repeat (5) pulse_one();
    n_chk++;
    if ({minutes, seconds} !== {7'd0, 6'd11})
      $display("FAIL paused_frozen: got %0d:%0d expected 0:11", minutes, seconds);
    else n_pass++;
  endtask

  task automatic test_adjust_blink();
    enter_adj(1); repeat (47) pulse_two();
    for (int i = 0; i < 62; i++) begin
      pulse_two();
      n_chk++;
      if ({minutes, seconds} !== {7'(m_min), 6'(m_sec)} || (i == 1 && seconds !== 6'd0))
        $display("FAIL adj_sec_step%0d: got %0d:%0d expected %0d:%0d",
                 i, minutes, seconds, m_min, m_sec);
      else n_pass++;
    end
    n_chk++;
    if ({minutes, seconds} !== {7'd0, 6'd0})
      $display("FAIL adj_sec_end: got %0d:%0d expected 0:0", minutes, seconds);
    else n_pass++;
    blink_clk = 0; clks(3);
    for (int f = 1; f >= 0; f--) begin
      sel = f[0];
      for (int i = 0; i < 4; i++) begin
        pulse_seg();
        n_chk++;
        if ({an, seg} !== {exp_an(m_idx), exp_seg(m_idx)})
          $display("FAIL blink_sel%0d_idx%0d: got an=%b seg=%b expected an=%b seg=%b",
                   f, m_idx, an, seg, exp_an(m_idx), exp_seg(m_idx));
        else n_pass++;
      end
    end
    blink_clk = 1; clks(3);
    n_chk++;
    if (seg !== exp_seg(m_idx))
      $display("FAIL blink_off: got seg=%b expected %b", seg, exp_seg(m_idx));
    else n_pass++;
    exit_adj();
  endtask

  task automatic test_pause_adj();
    enter_adj(1); pulse_pause(); exit_adj();
    pulse_one();
    n_chk++;
    if ({minutes, seconds} !== {7'd0, 6'd0})
      $display("FAIL resume_paused: got %0d:%0d expected 0:0", minutes, seconds);
    else n_pass++;
    pulse_pause(); pulse_one();
    n_chk++;
    if ({minutes, seconds} !== {7'd0, 6'd1})
      $display("FAIL unpause_run: got %0d:%0d expected 0:1", minutes, seconds);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: pulse_one();
        1: pulse_pause();
        2: begin
          enter_adj(1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 5)) begin
            if ($urandom_range(0, 3) == 0) pulse_pause();
            sel = 1'($urandom_range(0, 1));
            pulse_two();
          end
          exit_adj();
        end
        3: begin
          pulse_seg();
          n_chk++;
          if ({an, seg} !== {exp_an(m_idx), exp_seg(m_idx)})
            $display("FAIL rnd_disp%0d: got an=%b seg=%b expected an=%b seg=%b",
                     i, an, seg, exp_an(m_idx), exp_seg(m_idx));
          else n_pass++;
        end
        default: pulse_both();
      endcase
      n_chk++;
      if ({minutes, seconds} !== {7'(m_min), 6'(m_sec)})
        $display("FAIL rnd_count%0d: got %0d:%0d expected %0d:%0d",
                 i, minutes, seconds, m_min, m_sec);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    enter_adj(0);
    while (m_min != 5) pulse_two();
    sel = 1;
    while (m_sec != 17) pulse_two();
    exit_adj();
    if (m_paused) pulse_pause();
    n_chk++;
    if ({minutes, seconds} !== {7'd5, 6'd17})
      $display("FAIL mid_preload: got %0d:%0d expected 5:17", minutes, seconds);
    else n_pass++;
    one_hz = 1;
    @(posedge clk); #2 reset = 1; #1;
    n_chk++;
    if ({minutes, seconds, an, seg} !== {7'd0, 6'd0, 4'hF, 7'h7F})
      $display("FAIL mid_reset: got %0d:%0d an=%b seg=%b expected 0:0 an=1111 seg=1111111",
               minutes, seconds, an, seg);
    else n_pass++;
    one_hz = 0; clks(2); reset = 0; m_reset(); clks(3);
    n_chk++;
    if ({minutes, seconds, an} !== {7'd0, 6'd0, 4'b1110})
      $display("FAIL mid_no_pending: got %0d:%0d an=%b expected 0:0 an=1110",
               minutes, seconds, an);
    else n_pass++;
    pulse_one();
    n_chk++;
    if ({minutes, seconds} !== {7'd0, 6'd1})
      $display("FAIL mid_restart: got %0d:%0d expected 0:1", minutes, seconds);
    else n_pass++;
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    enter_adj(1);
    while (m_sec != 20) pulse_two();
    exit_adj();
    pulse_lap();
    repeat (4) pulse_one();
    n_chk++;
    if (seconds !== 6'd24) $display("FAIL lap_live: got %0d expected 24", seconds);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pulse_seg();
      n_chk++;
      if (seg !== exp_seg(m_idx) || (m_idx == 1 && seg !== 7'b0100100))
        $display("FAIL lap_frozen_idx%0d: got seg=%b expected %b", m_idx, seg, exp_seg(m_idx));
      else n_pass++;
    end
    pulse_lap();
    for (int i = 0; i < 4; i++) begin
      pulse_seg();
      n_chk++;
      if (seg !== exp_seg(m_idx))
        $display("FAIL lap_unfrozen_idx%0d: got seg=%b expected %b", m_idx, seg, exp_seg(m_idx));
      else n_pass++;
    end
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_count_scan();
    test_carry();
    test_simul();
    test_adjust_blink();
    test_pause_adj();
    test_random();
    test_reset_mid();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequences the stopwatch datapath from the level clocks produced by the clock divider (1 Hz, 2 Hz, segment-scan and blink square waves).
- Detects rising edges of those levels in the clk domain and runs a RUN/PAUSED/ADJUST state machine.
- Maintains an MM:SS count and time-multiplexes the single 4-digit 7-segment display among the digits, blinking the field being adjusted.

Parameters:
MAX_MIN, 99, highest minute value before wrap to 0; legal range 1..99.
ANODE_ACTIVE_LOW, 1, 1 = an[] active-low, 0 = active-high; seg[] is always active-low.

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high
one_hz  in  1  1 Hz square wave from the divider
two_hz  in  1  2 Hz square wave from the divider
seg_clk  in  1  display-scan square wave from the divider
blink_clk  in  1  blink square wave from the divider
pause_btn  in  1  debounced level; each rising edge toggles run/pause
adj  in  1  debounced level; 1 = adjust mode
sel  in  1  adjust field: 0 = minutes, 1 = seconds
minutes  out  7  current minutes, 0..MAX_MIN
seconds  out  6  current seconds, 0..59
an  out  4  digit enables, one-hot; an[3] = min tens, an[0] = sec ones
seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset is asynchronous and active-high on clk; all state is flopped on posedge clk.
- Reset values:
  - state = RUN, minutes = 0, seconds = 0, scan index = 0, resume flag = RUN.
  - an = all digits disabled (4'b1111 when ANODE_ACTIVE_LOW = 1), seg = 7'h7F.
  - All edge-detect history flops = 1, so a level that is high at reset release produces no edge.
- Edge detect:
  - Each of the six level inputs (one_hz, two_hz, seg_clk, blink_clk, pause_btn, adj) is registered once.
  - An event is a single-cycle pulse when the registered value is 1 and the previous value was 0.
  - Event latency is 1 clk after the input rises.
- States:
  - RUN: on a one_hz event, seconds increments. 59 -> 0 with minutes+1. MAX_MIN:59 -> 00:00.
  - PAUSED: count is frozen.
  - ADJUST: 1 Hz counting is suspended. On a two_hz event, the selected field increments with no carry. Seconds wrap 59 -> 0. Minutes wrap MAX_MIN -> 0.
- Transitions:
  - adj registered high from RUN or PAUSED -> ADJUST; the prior state is saved in the resume flag.
  - adj registered low in ADJUST -> resume-flag state.
  - pause event: RUN <-> PAUSED. Ignored in ADJUST; the resume flag is not toggled.
- Simultaneous events:
  - one_hz event and pause event in the same cycle in RUN: the increment is applied and the state becomes PAUSED.
  - adj rise and one_hz event in the same cycle: ADJUST wins and there is no increment.
- sel may change at any time; it takes effect on the next two_hz event and the next display refresh.
- Display scan:
  - On each seg_clk event, scan index advances 0 -> 1 -> 2 -> 3 -> 0.
  - an and seg are registered and update 1 clk after the index changes.
  - Digit mapping: index 0 = seconds%10, 1 = seconds/10, 2 = minutes%10, 3 = minutes/10.
  - Division is done by combinational constant compare/subtract; no divider IP.
- Blink: in ADJUST with registered blink_clk = 0, the two digits of the selected field drive seg = 7'h7F. The anode is still driven.
- Segment codes (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Reset mid-operation: immediate return to the reset values. No pending event survives reset.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- When defined:
  - Adds an input port lap (1 bit, debounced level).
  - A lap rising edge in RUN toggles a freeze flag. While frozen, the display shows a snapshot of MM:SS latched at the lap edge; minutes/seconds outputs and counting continue live.
  - The freeze flag is cleared by reset, by entering ADJUST, and by a second lap edge.
- When undefined: no lap port, no snapshot registers; the display always shows the live count.

Test Plan:
- Reset, then 3 one_hz rising edges in RUN -> seconds = 3, minutes = 0; an scans 1110, 1101, 1011, 0111 on successive seg_clk edges; digit 0 seg = 0110000.
- Preload 01:59 via ADJUST, release adj in RUN, 1 one_hz edge -> 02:00. With MAX_MIN = 99 from 99:59 -> 00:00.
- pause_btn edge in the same cycle as a one_hz edge at 00:10 -> 00:11 and PAUSED; 5 more one_hz edges -> still 00:11.
- adj = 1, sel = 1, 62 two_hz edges from 00:58 -> seconds = 0 after 2 edges, ending 00:00 with minutes unchanged. Digits 1 and 0 show 7'h7F whenever blink_clk = 0.
- PAUSED, then adj high and low -> returns to PAUSED; a pause_btn edge during ADJUST is ignored.
- Assert reset mid-count at 05:17 -> minutes = 0, seconds = 0, an = 1111, seg = 7'h7F within 0 clk. With STOPWATCH_LAP_EN, a lap edge at 00:20 and 4 one_hz edges -> display shows 00:20, seconds output = 24.
